bus_splitter_32: RTL and testbench
==================================

BUS_SPLITTER_32 -- requirements
Module: bus_splitter_32

Interface
REQ-001 SHALL have parameter: LINE_WORDS, 8, number of 32b downstream beats per LINE_READ (4 x 64b line).
REQ-002 SHALL have port: clock  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: ARESETn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: up_cycle  input  1  CPU request valid; held with stable fields until up_ack.
REQ-005 SHALL have port: up_paddr  input  32  CPU physical byte address.
REQ-006 SHALL have port: up_access  input  execute::memory_access_t  access type.
REQ-007 SHALL have port: up_data_out  input  64  CPU write data.
REQ-008 SHALL have port: up_data_in  output  4x64  assembled read data, lane 0 first.
REQ-009 SHALL have port: up_ack  output  1  one-cycle completion pulse to CPU.
REQ-010 SHALL have port: dn_cycle  output  1  32b beat request to AXI-Lite translator.
REQ-011 SHALL have port: dn_paddr  output  32  beat byte address, 4-byte aligned except sub-word writes.
REQ-012 SHALL have port: dn_access  output  execute::memory_access_t  beat access type.
REQ-013 SHALL have port: dn_data_out  output  64  beat write data in [31:0], [63:32] zero.
REQ-014 SHALL have port: dn_data_in  input  4x64  beat read data, only lane 0 [31:0] used.
REQ-015 SHALL have port: dn_ack  input  1  beat complete when sampled high while dn_cycle high.

Function
REQ-016 SHALL implement states IDLE, BUSY, RESP; all outputs registered except up_data_in (driven from word buffer).
REQ-017 IDLE with up_cycle=1 SHALL latch access/data, compute base address and beat count N, set idx=0, go BUSY, assert dn_cycle next cycle.
REQ-018 Decomposition: BYTE/HWORD/WORD_READ -> 1 WORD_READ at paddr&~3; DWORD_READ -> 2 WORD_READ at paddr&~7, +4; LINE_READ -> LINE_WORDS WORD_READ at paddr&~31, +4 each.
REQ-019 Decomposition: WORD_WRITE -> 1 WORD_WRITE at paddr&~3, data up_data_out[31:0]; DWORD_WRITE -> 2 WORD_WRITE at paddr&~7 (data [31:0]) and +4 (data [63:32]).
REQ-020 BYTE/HWORD_WRITE SHALL forward as 1 beat with original access, unmodified paddr, data up_data_out[31:0].
REQ-021 Any other up_access SHALL issue no beat, go directly to RESP with word buffer zeroed.
REQ-022 BUSY: dn_paddr = base + 4*idx; dn_cycle, dn_paddr, dn_access, dn_data_out stable until dn_ack.
REQ-023 BUSY on dn_ack of a read beat SHALL store dn_data_in[0][31:0] into word buffer[idx].
REQ-024 BUSY on dn_ack with idx<N-1 SHALL increment idx; next beat's fields appear on the following cycle, dn_cycle stays high (back-to-back).
REQ-025 BUSY on dn_ack with idx==N-1 SHALL clear dn_cycle and go RESP next cycle.
REQ-026 RESP SHALL assert up_ack for exactly one cycle, then return to IDLE; IDLE SHALL NOT accept up_cycle in the RESP cycle.
REQ-027 up_data_in[i] SHALL equal {word[2i+1], word[2i]} for LINE_READ and DWORD_READ (lane 0 only, other lanes zero).
REQ-028 Sub-word and WORD reads: up_data_in[0] = paddr[2] ? {word0, 32'b0} : {32'b0, word0}; other lanes zero.
REQ-029 up_data_in SHALL hold until next request is latched; writes SHALL return all-zero up_data_in.
REQ-030 dn_ack while dn_cycle=0 SHALL be ignored; latency = sum of beat latencies + 2 cycles.

Reset
REQ-031 ARESETn=0 at clock edge SHALL force IDLE, idx=0, word buffer zero, dn_cycle=0, dn_paddr=0, dn_access=0, dn_data_out=0, up_ack=0.
REQ-032 Reset mid-BUSY SHALL abort the request without up_ack; dn_cycle low on first reset edge.

Verification
REQ-033 WORD_READ paddr 0x1004, dn_data_in[0]=0xDEADBEEF after 3 cycles -> one beat at 0x1004, up_ack once, up_data_in[0]=0xDEADBEEF_00000000.
REQ-034 LINE_READ paddr 0x2014, beat k returns 0x100+k, 1-cycle ack each -> 8 beats 0x2000..0x201C back-to-back, up_data_in[3]=0x00000107_00000106.
REQ-035 DWORD_WRITE paddr 0x3000 data 0x11223344_55667788 -> beats (0x3000, 0x55667788), (0x3004, 0x11223344), up_ack once, no read data.
REQ-036 BYTE_WRITE paddr 0x4003 data 0xAB -> single BYTE_WRITE beat at 0x4003, dn_data_out=0x000000AB, up_ack.
REQ-037 LINE_READ, ARESETn low after beat 3 ack -> dn_cycle=0 next edge, no up_ack, buffer zero; new WORD_READ after reset completes normally.

Source files
------------

// File: rtl/execute.sv
// rtl/execute.sv - memory access type shared by the CPU side and the bus splitter
package execute;

  typedef enum logic [3:0] {
    ACCESS_NONE = 4'd0,
    BYTE_READ   = 4'd1,
    HWORD_READ  = 4'd2,
    WORD_READ   = 4'd3,
    DWORD_READ  = 4'd4,
    LINE_READ   = 4'd5,
    BYTE_WRITE  = 4'd6,
    HWORD_WRITE = 4'd7,
    WORD_WRITE  = 4'd8,
    DWORD_WRITE = 4'd9
  } memory_access_t;

endpackage

// File: rtl/bus_splitter_32.sv
// rtl/bus_splitter_32.sv - splits 64b/line CPU accesses into 32b beats for the AXI-Lite translator
module bus_splitter_32
  import execute::*;
#(
  parameter int LINE_WORDS = 8
) (
  input  logic                 clock,
  input  logic                 ARESETn,
  input  logic                 up_cycle,
  input  logic [31:0]          up_paddr,
  input  memory_access_t       up_access,
  input  logic [63:0]          up_data_out,
  output logic [3:0][63:0]     up_data_in,
  output logic                 up_ack,
  output logic                 dn_cycle,
  output logic [31:0]          dn_paddr,
  output memory_access_t       dn_access,
  output logic [63:0]          dn_data_out,
  input  logic [3:0][63:0]     dn_data_in,
  input  logic                 dn_ack
);

  localparam int BUF_WORDS = (LINE_WORDS > 8) ? LINE_WORDS : 8;
  localparam int IDX_W     = $clog2(BUF_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                        state;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              last_idx;
  logic [31:0]                   base;
  logic [BUF_WORDS-1:0][31:0]    words;
  memory_access_t                cur_access;
  logic                          hi_half;
  logic [31:0]                   wr_hi;

  logic [31:0]                   req_base;
  logic [IDX_W-1:0]              req_last;
  memory_access_t                req_dn_access;
  logic                          req_valid;
  logic                          req_write;
  logic [IDX_W-1:0]              idx_next;

  logic unused_dn_bits;
  assign unused_dn_bits = ^{dn_data_in[3:1], dn_data_in[0][63:32]};

  assign idx_next = idx + IDX_W'(1);

  // Request decode: beat base address, last beat index and the beat access type.
  always_comb begin
    req_base      = {up_paddr[31:2], 2'b00};
    req_last      = '0;
    req_dn_access = WORD_READ;
    req_valid     = 1'b1;
    req_write     = 1'b0;
    case (up_access)
      BYTE_READ, HWORD_READ, WORD_READ: ;
      DWORD_READ: begin
        req_base = {up_paddr[31:3], 3'b000};
        req_last = IDX_W'(1);
      end
      LINE_READ: begin
        req_base = {up_paddr[31:5], 5'b00000};
        req_last = IDX_W'(LINE_WORDS - 1);
      end
      WORD_WRITE: begin
        req_dn_access = WORD_WRITE;
        req_write     = 1'b1;
      end
      DWORD_WRITE: begin
        req_base      = {up_paddr[31:3], 3'b000};
        req_last      = IDX_W'(1);
        req_dn_access = WORD_WRITE;
        req_write     = 1'b1;
      end
      BYTE_WRITE, HWORD_WRITE: begin
        req_base      = up_paddr;
        req_dn_access = up_access;
        req_write     = 1'b1;
      end
      default: req_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!ARESETn) begin
      state       <= IDLE;
      idx         <= '0;
      last_idx    <= '0;
      base        <= '0;
      words       <= '0;
      cur_access  <= ACCESS_NONE;
      hi_half     <= 1'b0;
      wr_hi       <= '0;
      up_ack      <= 1'b0;
      dn_cycle    <= 1'b0;
      dn_paddr    <= '0;
      dn_access   <= ACCESS_NONE;
      dn_data_out <= '0;
    end else begin
      up_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (up_cycle) begin
            words      <= '0;
            cur_access <= up_access;
            hi_half    <= up_paddr[2];
            idx        <= '0;
            base       <= req_base;
            last_idx   <= req_last;
            wr_hi      <= req_write ? up_data_out[63:32] : 32'h0;
            if (req_valid) begin
              state       <= BUSY;
              dn_cycle    <= 1'b1;
              dn_paddr    <= req_base;
              dn_access   <= req_dn_access;
              dn_data_out <= req_write ? {32'h0, up_data_out[31:0]} : 64'h0;
            end else begin
              state  <= RESP;
              up_ack <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (dn_cycle && dn_ack) begin
            if (dn_access == WORD_READ)
              words[idx] <= dn_data_in[0][31:0];
            if (idx != last_idx) begin
              // Only a DWORD write has a second beat with data; it carries the high half.
              idx         <= idx_next;
              dn_paddr    <= base + {{(30 - IDX_W){1'b0}}, idx_next, 2'b00};
              dn_data_out <= {32'h0, wr_hi};
            end else begin
              dn_cycle <= 1'b0;
              state    <= RESP;
              up_ack   <= 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is assembled from the word buffer so it stays valid until the next request.
  always_comb begin
    up_data_in = '0;
    case (cur_access)
      LINE_READ: begin
        for (int i = 0; i < 4; i++)
          up_data_in[i] = {words[2*i+1], words[2*i]};
      end
      DWORD_READ: up_data_in[0] = {words[1], words[0]};
      BYTE_READ, HWORD_READ, WORD_READ:
        up_data_in[0] = hi_half ? {words[0], 32'h0} : {32'h0, words[0]};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_splitter_32.sv
// tb/tb_bus_splitter_32.sv - directed self-checking bench for bus_splitter_32
module tb_bus_splitter_32;
  import execute::*;

  logic               clock = 1'b0;
  logic               ARESETn;
  logic               up_cycle;
  logic [31:0]        up_paddr;
  memory_access_t     up_access;
  logic [63:0]        up_data_out;
  logic [3:0][63:0]   up_data_in;
  logic               up_ack;
  logic               dn_cycle;
  logic [31:0]        dn_paddr;
  memory_access_t     dn_access;
  logic [63:0]        dn_data_out;
  logic [3:0][63:0]   dn_data_in;
  logic               dn_ack;

  int total = 0;
  int bad   = 0;
  logic [3:0][63:0] exp_lines;

  always #5 clock = ~clock;

  bus_splitter_32 #(.LINE_WORDS(8)) dut (
    .clock       (clock),
    .ARESETn     (ARESETn),
    .up_cycle    (up_cycle),
    .up_paddr    (up_paddr),
    .up_access   (up_access),
    .up_data_out (up_data_out),
    .up_data_in  (up_data_in),
    .up_ack      (up_ack),
    .dn_cycle    (dn_cycle),
    .dn_paddr    (dn_paddr),
    .dn_access   (dn_access),
    .dn_data_out (dn_data_out),
    .dn_data_in  (dn_data_in),
    .dn_ack      (dn_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input memory_access_t acc, input logic [31:0] a, input logic [63:0] d);
    up_cycle    = 1'b1;
    up_access   = acc;
    up_paddr    = a;
    up_data_out = d;
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input memory_access_t acc,
                      input logic [31:0] d, input int lat, input logic [31:0] rd, input bit b2b);
    int waited = 0;
    while (!dn_cycle && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    chk({tag, ".cyc"}, 64'(dn_cycle), 64'(1));
    if (b2b) chk({tag, ".b2b"}, 64'(waited), 64'(0));
    chk({tag, ".paddr"}, 64'(dn_paddr), 64'(a));
    chk({tag, ".access"}, 64'(dn_access), 64'(acc));
    chk({tag, ".wdata"}, dn_data_out, {32'h0, d});
    for (int k = 1; k < lat; k++) @(negedge clock);
    if (lat > 1) chk({tag, ".hold"}, 64'(dn_paddr), 64'(a));
    dn_data_in[0] = {32'hFFFF_FFFF, rd};
    dn_ack        = 1'b1;
    @(negedge clock);
    dn_ack     = 1'b0;
    dn_data_in = '0;
  endtask

  task automatic done_req(input string tag);
    chk({tag, ".ack"}, 64'(up_ack), 64'(1));
    chk({tag, ".dn_idle"}, 64'(dn_cycle), 64'(0));
    up_cycle = 1'b0;
    @(negedge clock);
    chk({tag, ".ack_once"}, 64'(up_ack), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn     = 1'b0;
    up_cycle    = 1'b0;
    up_paddr    = '0;
    up_access   = ACCESS_NONE;
    up_data_out = '0;
    dn_data_in  = '0;
    dn_ack      = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst.dn_cycle", 64'(dn_cycle), 64'(0));
    chk("rst.up_ack", 64'(up_ack), 64'(0));
    chk("rst.dn_paddr", 64'(dn_paddr), 64'(0));
    chk("rst.dn_access", 64'(dn_access), 64'(ACCESS_NONE));
    chk("rst.dn_data_out", dn_data_out, 64'h0);
    chk_wide("rst.up_data_in", up_data_in, 256'h0);
    ARESETn = 1'b1;

    // Stray dn_ack while idle must do nothing.
    dn_ack = 1'b1;
    @(negedge clock);
    dn_ack = 1'b0;
    chk("stray.dn_cycle", 64'(dn_cycle), 64'(0));
    chk("stray.up_ack", 64'(up_ack), 64'(0));

    // WORD_READ at 0x1004, 3-cycle beat.
    request(WORD_READ, 32'h1004, 64'h0);
    beat("t1", 32'h1004, WORD_READ, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    done_req("t1");
    chk_wide("t1.rdata", up_data_in, {192'h0, 64'hDEADBEEF_00000000});

    // LINE_READ at 0x2014, eight back-to-back 1-cycle beats.
    request(LINE_READ, 32'h2014, 64'h0);
    for (int k = 0; k < 8; k++)
      beat($sformatf("t2.b%0d", k), 32'h2000 + 32'(4 * k), WORD_READ, 32'h0, 1,
           32'h100 + 32'(k), k != 0);
    done_req("t2");
    chk("t2.lane3", up_data_in[3], 64'h00000107_00000106);
    for (int i = 0; i < 4; i++)
      exp_lines[i] = {32'h100 + 32'(2 * i + 1), 32'h100 + 32'(2 * i)};
    chk_wide("t2.rdata", up_data_in, exp_lines);

    // DWORD_WRITE at 0x3000: low half first, then high half.
    request(DWORD_WRITE, 32'h3000, 64'h11223344_55667788);
    beat("t3.b0", 32'h3000, WORD_WRITE, 32'h55667788, 2, 32'hBAD0_BAD0, 1'b0);
    beat("t3.b1", 32'h3004, WORD_WRITE, 32'h11223344, 1, 32'hBAD1_BAD1, 1'b1);
    done_req("t3");
    chk_wide("t3.rdata", up_data_in, 256'h0);

    // BYTE_WRITE forwarded untouched.
    request(BYTE_WRITE, 32'h4003, 64'h0000_0000_0000_00AB);
    beat("t4", 32'h4003, BYTE_WRITE, 32'h0000_00AB, 1, 32'h5555_5555, 1'b0);
    done_req("t4");
    chk_wide("t4.rdata", up_data_in, 256'h0);

    // DWORD_READ at 0x500C aligns down to 0x5008.
    request(DWORD_READ, 32'h500C, 64'h0);
    beat("t5.b0", 32'h5008, WORD_READ, 32'h0, 1, 32'hA0A0_A0A0, 1'b0);
    beat("t5.b1", 32'h500C, WORD_READ, 32'h0, 2, 32'hB1B1_B1B1, 1'b1);
    done_req("t5");
    chk_wide("t5.rdata", up_data_in, {192'h0, 64'hB1B1B1B1_A0A0A0A0});

    // HWORD_READ at 0x6002: low 32 bits of lane 0.
    request(HWORD_READ, 32'h6002, 64'h0);
    beat("t6", 32'h6000, WORD_READ, 32'h0, 1, 32'h1234_5678, 1'b0);
    done_req("t6");
    chk_wide("t6.rdata", up_data_in, {192'h0, 64'h00000000_12345678});

    // Unsupported access: no beat, immediate response, zero data.
    request(ACCESS_NONE, 32'h7777, 64'h0);
    @(negedge clock);
    done_req("t7");
    chk_wide("t7.rdata", up_data_in, 256'h0);

    // Reset in the middle of a LINE_READ.
    request(LINE_READ, 32'h8000, 64'h0);
    for (int k = 0; k < 4; k++)
      beat($sformatf("t8.b%0d", k), 32'h8000 + 32'(4 * k), WORD_READ, 32'h0, 1,
           32'h200 + 32'(k), k != 0);
    chk("t8.pre_cyc", 64'(dn_cycle), 64'(1));
    ARESETn  = 1'b0;
    up_cycle = 1'b0;
    @(negedge clock);
    chk("t8.rst_cyc", 64'(dn_cycle), 64'(0));
    chk("t8.rst_ack", 64'(up_ack), 64'(0));
    chk("t8.rst_paddr", 64'(dn_paddr), 64'(0));
    chk_wide("t8.rst_data", up_data_in, 256'h0);
    ARESETn = 1'b1;
    @(negedge clock);
    chk("t8.no_ack", 64'(up_ack), 64'(0));
    chk("t8.idle_cyc", 64'(dn_cycle), 64'(0));

    request(WORD_READ, 32'h1008, 64'h0);
    beat("t9", 32'h1008, WORD_READ, 32'h0, 2, 32'hCAFE_F00D, 1'b0);
    done_req("t9");
    chk_wide("t9.rdata", up_data_in, {192'h0, 64'h00000000_CAFEF00D});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
